fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Issue/writeback controller that sits directly upstream of the FPU execution units (fadd/fsub/fmul/fdiv/fsqrt and the sign units fabs, fneg, fsgnj, fsgnjn, fsgnjx).
- Accepts decoded FP ops over a valid/ready handshake and checks register hazards against a 32-entry busy scoreboard.
- Reserves a writeback slot at the op's fixed latency, then emits a single-port writeback strobe when the result appears.
- Guarantees that no two results ever collide on the FP register-file write port.

Parameters:
LAT_ADD, 3, cycles for fadd/fsub (1..DEPTH)
LAT_MUL, 2, cycles for fmul (1..DEPTH)
LAT_DIV, 12, cycles for fdiv (1..DEPTH)
LAT_SQRT, 12, cycles for fsqrt (1..DEPTH)
DEPTH, 16, writeback reservation slots; must be >= max latency

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all in-flight ops
in_valid  in  1  op offered
in_ready  out  1  op accepted this cycle when in_valid&in_ready
in_op  in  4  fpu_op_t opcode
in_rd  in  5  destination FP register
in_rs1  in  5  source 1
in_rs2  in  5  source 2 (ignored for unary ops)
issue_valid  out  1  start pulse to execution unit (combinational, = accept & legal)
issue_op  out  4  opcode to execution unit (= in_op)
wb_valid  out  1  result write strobe (registered)
wb_rd  out  5  register written
wb_op  out  4  opcode whose result is on the FPU result bus
busy  out  32  scoreboard, bit i = register i pending
illegal_op  out  1  registered one-cycle pulse: illegal opcode accepted

Behaviour:
- Reset (sync, rst=1 at posedge): all slots invalid, busy=0, wb_valid=0, wb_rd=0, wb_op=0, illegal_op=0. in_ready=0 while rst=1, regardless of other inputs. Reset mid-flight drops all pending writebacks silently.
- Latency L(op): sign ops (FSGNJ, FSGNJN, FSGNJX, FABS, FNEG) = 1; add/sub = LAT_ADD; mul = LAT_MUL; div = LAT_DIV; sqrt = LAT_SQRT.
- Unary ops (FABS, FNEG, FSQRT): rs2 is not checked.
- Slot register slot[0..DEPTH-1], each holding {valid, rd, op}. Every cycle slot[k] <= slot[k+1], and slot[DEPTH-1] <= invalid.
- On accept in cycle T: slot[L-1] <= {1, in_rd, in_op}. The new entry takes precedence over the shifted-in value, which must be invalid by the slot rule below.
- wb_valid/wb_rd/wb_op are driven by slot[0], so writeback appears exactly in cycle T+L.
- in_ready = ~rst & ~flush & ~busy[rs1] & (unary | ~busy[rs2]) & ~busy[rd] & slot_free.
  - slot_free = ~slot[L].valid, with slot[DEPTH] treated as always free.
  - The rd check provides WAW protection.
  - in_ready may depend on in_op/in_r* (combinational), but it must not depend on in_valid.
- Scoreboard: on accept, busy[in_rd] <= 1. When slot[0].valid, busy[slot[0].rd] <= 0.
  - Same-rd set and clear in one cycle cannot occur because the WAW check stalls it.
  - If both events hit different registers in the same cycle, both apply.
  - No bypass: an op reading register r stalls until the cycle after wb of r.
- Illegal opcode (encoding > 9): accepted if in_ready; no slot, no busy bit, issue_valid=0; illegal_op=1 in T+1.
- flush=1 at posedge: all slots invalid, busy=0. wb_valid=0 from the next cycle. An op offered during flush is not accepted. Flush overrides accept; rst overrides flush.
- Back-to-back issue of 1-cycle ops is allowed every cycle (full throughput).

Decomposition:
- Package fpu_pkg:
  - fpu_op_t 4-bit enum: FADD=0, FSUB=1, FMUL=2, FDIV=3, FSQRT=4, FSGNJ=5, FSGNJN=6, FSGNJX=7, FABS=8, FNEG=9.
  - Function is_unary(op).
  - Typedef wb_slot_t {valid, rd, op}.
  - Latency function taking the parameters.
- One natural sub-module: fpu_wb_slots, the shift/reserve register with an insert port and a slot_free query.

Test Plan:
- Reset then FABS rd=3 rs1=1 at T -> in_ready=1, issue_valid=1 at T; wb_valid=1, wb_rd=3, wb_op=FABS at T+1; busy[3] high only during T+1.
- FADD rd=4 at T, then FSGNJ rd=5 at T+2 -> both would write back at T+3, so in_ready=0 at T+2; FSGNJ accepted at T+3 and writes back at T+4.
- FMUL rd=7 at T, then FNEG rd=8 rs1=7 -> stalled until busy[7] clears; accepted at T+3 (wb of 7 at T+2).
- FDIV rd=2 at T, flush at T+4 -> busy=0 at T+5; no wb_valid through T+12; a new FSGNJX rd=2 is accepted at T+5.
- FSQRT rd=1 rs1=0 rs2=9 with busy[9]=1 -> accepted (unary, rs2 ignored); wb at T+12.
- in_op=4'hF at T -> issue_valid=0, illegal_op=1 at T+1, busy unchanged, no wb_valid; rst asserted with 3 ops in flight -> all outputs 0 next cycle, no further wb.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU issue/writeback controller.
// Opcode encoding, writeback slot record, unary classification and per-op latency.
package fpu_pkg;

  typedef enum logic [3:0] {
    FADD   = 4'd0,
    FSUB   = 4'd1,
    FMUL   = 4'd2,
    FDIV   = 4'd3,
    FSQRT  = 4'd4,
    FSGNJ  = 4'd5,
    FSGNJN = 4'd6,
    FSGNJX = 4'd7,
    FABS   = 4'd8,
    FNEG   = 4'd9
  } fpu_op_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [3:0] op;
  } wb_slot_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'd9);
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return (op == FABS) || (op == FNEG) || (op == FSQRT);
  endfunction

  // Illegal encodings fall to the default and are treated as single-cycle for the slot check.
  function automatic int unsigned op_latency(input logic [3:0] op,
                                             input int unsigned lat_add,
                                             input int unsigned lat_mul,
                                             input int unsigned lat_div,
                                             input int unsigned lat_sqrt);
    int unsigned lat;
    case (op)
      FADD, FSUB: lat = lat_add;
      FMUL:       lat = lat_mul;
      FDIV:       lat = lat_div;
      FSQRT:      lat = lat_sqrt;
      default:    lat = 32'd1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Op-in / issue / writeback bundle between the decoder, this controller and the FPU.
interface fpu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [3:0]  wb_op;
  logic [31:0] busy;
  logic        illegal_op;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  in_ready, issue_valid, issue_op, wb_valid, wb_rd, wb_op, busy, illegal_op
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    output in_ready, issue_valid, issue_op, wb_valid, wb_rd, wb_op, busy, illegal_op
  );
endinterface

// File: rtl/fpu_wb_slots.sv
// Writeback reservation shift register: slot k holds the result due k cycles from now.
// Insertion lands at slot lat-1; free_o reports whether slot lat is empty (slot DEPTH is always empty).
module fpu_wb_slots
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          ins_en_i,
  input  logic [IW-1:0] lat_i,
  input  wb_slot_t      ins_slot_i,
  output logic          free_o,
  output wb_slot_t      head_o
);

  wb_slot_t       slot_q  [DEPTH];
  wb_slot_t       slot_d  [DEPTH];
  wb_slot_t       shift_s [DEPTH];
  logic [DEPTH:0] valid_s;

  // Occupancy view extended by one always-empty position past the top.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_s[k] = slot_q[k].valid;
    end
    valid_s[DEPTH] = 1'b0;
  end

  assign free_o = ~valid_s[lat_i];
  assign head_o = slot_q[0];

  // Shift toward slot 0; a new reservation overrides the (known empty) shifted-in entry.
  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      shift_s[k] = slot_q[k + 1];
    end
    shift_s[DEPTH - 1] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ins_en_i && (int'(lat_i) == k + 1)) begin
        slot_d[k] = ins_slot_i;
      end else begin
        slot_d[k] = shift_s[k];
      end
    end
  end

  // Slot storage; reset and flush both drop every reservation.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue/writeback controller: hazard-checked issue against a busy scoreboard and
// fixed-latency writeback slot reservation so results never collide on the write port.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 12,
  parameter int unsigned DEPTH    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  fpu_issue_ctrl_if.slave  bus
);

  localparam int unsigned IW = $clog2(DEPTH + 1);

  logic [IW-1:0] lat_s;
  logic          legal_s;
  logic          unary_s;
  logic          slot_free_s;
  logic          ready_s;
  logic          accept_s;
  logic          reserve_s;
  wb_slot_t      ins_s;
  wb_slot_t      head_s;
  logic [31:0]   set_mask_s;
  logic [31:0]   clr_mask_s;
  logic [31:0]   busy_q;
  logic [31:0]   busy_d;
  logic          illegal_q;

  assign lat_s   = IW'(op_latency(bus.in_op, LAT_ADD, LAT_MUL, LAT_DIV, LAT_SQRT));
  assign legal_s = is_legal(bus.in_op);
  assign unary_s = is_unary(bus.in_op);

  // Deliberately independent of in_valid so upstream can use it to decide whether to offer.
  assign ready_s = ~rst & ~flush
                 & ~busy_q[bus.in_rs1]
                 & (unary_s | ~busy_q[bus.in_rs2])
                 & ~busy_q[bus.in_rd]
                 & slot_free_s;

  assign accept_s  = bus.in_valid & ready_s;
  assign reserve_s = accept_s & legal_s;
  assign ins_s     = {1'b1, bus.in_rd, bus.in_op};

  fpu_wb_slots #(.DEPTH(DEPTH)) u_slots (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (flush),
    .ins_en_i   (reserve_s),
    .lat_i      (lat_s),
    .ins_slot_i (ins_s),
    .free_o     (slot_free_s),
    .head_o     (head_s)
  );

  assign set_mask_s = reserve_s    ? (32'd1 << bus.in_rd)  : 32'd0;
  assign clr_mask_s = head_s.valid ? (32'd1 << head_s.rd)  : 32'd0;
  assign busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;

  // Scoreboard and illegal-op pulse; reset beats flush, flush beats accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 32'd0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      busy_q    <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      illegal_q <= accept_s & ~legal_s;
    end
  end

  assign bus.in_ready    = ready_s;
  assign bus.issue_valid = reserve_s;
  assign bus.issue_op    = bus.in_op;
  assign bus.wb_valid    = head_s.valid;
  assign bus.wb_rd       = head_s.rd;
  assign bus.wb_op       = head_s.op;
  assign bus.busy        = busy_q;
  assign bus.illegal_op  = illegal_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed vector table, hand sequences for
// flush and unary-rs2 cases, then randomized traffic against a due-time reference model.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl_if bus();

  fpu_issue_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    bit          r, f, v;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    bit          rdy, iss, wbv;
    logic [4:0]  wbrd;
    logic [3:0]  wbop;
    logic [31:0] busy;
    bit          ill;
  } vec_t;

  typedef struct {
    int         due;
    logic [4:0] rd;
    logic [3:0] op;
  } pend_t;

  vec_t  tbl [24];
  pend_t pq  [$];
  pend_t keep[$];

  function automatic vec_t mk(bit r, bit f, bit v, logic [3:0] op, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, bit rdy, bit iss, bit wbv,
                              logic [4:0] wbrd, logic [3:0] wbop, logic [31:0] busy, bit ill);
    vec_t x;
    x.r = r; x.f = f; x.v = v; x.op = op; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
    x.rdy = rdy; x.iss = iss; x.wbv = wbv; x.wbrd = wbrd; x.wbop = wbop;
    x.busy = busy; x.ill = ill;
    return x;
  endfunction

  function automatic int m_lat(logic [3:0] op);
    if (op == FADD || op == FSUB) return 3;
    if (op == FMUL) return 2;
    if (op == FDIV || op == FSQRT) return 12;
    return 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic apply(input bit r, input bit f, input bit v, input logic [3:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    rst = r; flush = f;
    bus.in_valid = v; bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, FADD, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference-model variables for the random phase
  logic [31:0] e_busy;
  bit          e_wbv, e_rdy, e_iss, e_ill, e_ill_nxt, e_free, e_acc;
  logic [4:0]  e_wbrd;
  logic [3:0]  e_wbop;
  bit          r_r, r_f, r_v;
  logic [3:0]  r_op;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  int          r_k, r_lat;

  initial begin
    // Idle row: FADD rd0/rs0, never hazarded in these sequences
    tbl[0]  = mk(1,0,1,FABS,  5'd3,5'd1,5'd2, 0,0,0,5'd0,4'd0,  32'h0,   0);
    tbl[1]  = mk(0,0,1,FABS,  5'd3,5'd1,5'd2, 1,1,0,5'd0,4'd0,  32'h0,   0);
    tbl[2]  = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,1,5'd3,FABS,  32'h8,   0);
    tbl[3]  = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,0,5'd0,4'd0,  32'h0,   0);
    tbl[4]  = mk(0,0,1,FADD,  5'd4,5'd1,5'd2, 1,1,0,5'd0,4'd0,  32'h0,   0);
    tbl[5]  = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,0,5'd0,4'd0,  32'h10,  0);
    tbl[6]  = mk(0,0,1,FSGNJ, 5'd5,5'd1,5'd2, 0,0,0,5'd0,4'd0,  32'h10,  0);
    tbl[7]  = mk(0,0,1,FSGNJ, 5'd5,5'd1,5'd2, 1,1,1,5'd4,FADD,  32'h10,  0);
    tbl[8]  = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,1,5'd5,FSGNJ, 32'h20,  0);
    tbl[9]  = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,0,5'd0,4'd0,  32'h0,   0);
    tbl[10] = mk(0,0,1,FMUL,  5'd7,5'd1,5'd2, 1,1,0,5'd0,4'd0,  32'h0,   0);
    tbl[11] = mk(0,0,1,FNEG,  5'd8,5'd7,5'd0, 0,0,0,5'd0,4'd0,  32'h80,  0);
    tbl[12] = mk(0,0,1,FNEG,  5'd8,5'd7,5'd0, 0,0,1,5'd7,FMUL,  32'h80,  0);
    tbl[13] = mk(0,0,1,FNEG,  5'd8,5'd7,5'd0, 1,1,0,5'd0,4'd0,  32'h0,   0);
    tbl[14] = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,1,5'd8,FNEG,  32'h100, 0);
    tbl[15] = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,0,5'd0,4'd0,  32'h0,   0);
    tbl[16] = mk(0,0,1,4'hF,  5'd6,5'd1,5'd2, 1,0,0,5'd0,4'd0,  32'h0,   0);
    tbl[17] = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,0,5'd0,4'd0,  32'h0,   1);
    tbl[18] = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,0,5'd0,4'd0,  32'h0,   0);
    tbl[19] = mk(0,0,1,FDIV,  5'd10,5'd1,5'd2,1,1,0,5'd0,4'd0,  32'h0,   0);
    tbl[20] = mk(0,0,1,FSQRT, 5'd11,5'd1,5'd2,1,1,0,5'd0,4'd0,  32'h400, 0);
    tbl[21] = mk(0,0,1,FADD,  5'd12,5'd1,5'd2,1,1,0,5'd0,4'd0,  32'hC00, 0);
    tbl[22] = mk(1,0,0,FADD,  5'd0,5'd0,5'd0, 0,0,0,5'd0,4'd0,  32'h1C00,0);
    tbl[23] = mk(0,0,0,FADD,  5'd0,5'd0,5'd0, 1,0,0,5'd0,4'd0,  32'h0,   0);

    apply(1'b1, 1'b0, 1'b0, FADD, 5'd0, 5'd0, 5'd0);
    step();

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2);
      chk($sformatf("v%0d_ready", i),  bus.in_ready,    tbl[i].rdy);
      chk($sformatf("v%0d_issue", i),  bus.issue_valid, tbl[i].iss);
      chk($sformatf("v%0d_wbv", i),    bus.wb_valid,    tbl[i].wbv);
      chk($sformatf("v%0d_wbrd", i),   bus.wb_rd,       tbl[i].wbrd);
      chk($sformatf("v%0d_wbop", i),   bus.wb_op,       tbl[i].wbop);
      chk($sformatf("v%0d_busy", i),   bus.busy,        tbl[i].busy);
      chk($sformatf("v%0d_illegal", i), bus.illegal_op, tbl[i].ill);
      if (tbl[i].iss) chk($sformatf("v%0d_issue_op", i), bus.issue_op, tbl[i].op);
      step();
    end

    // Ops dropped by reset must never write back
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("post_rst_wbv", bus.wb_valid, 1'b0);
      chk("post_rst_busy", bus.busy, 32'h0);
      step();
    end

    // Flush: FDIV rd2 at T, flush at T+4
    apply(1'b0, 1'b0, 1'b1, FDIV, 5'd2, 5'd1, 5'd3);
    chk("fl_div_issue", bus.issue_valid, 1'b1);
    step();
    for (int i = 1; i <= 3; i++) begin idle(); step(); end
    apply(1'b0, 1'b1, 1'b1, FSGNJ, 5'd20, 5'd1, 5'd3);
    chk("fl_ready_during_flush", bus.in_ready, 1'b0);
    chk("fl_issue_during_flush", bus.issue_valid, 1'b0);
    chk("fl_busy_before", bus.busy, 32'h4);
    step();
    apply(1'b0, 1'b0, 1'b1, FSGNJX, 5'd2, 5'd1, 5'd3);
    chk("fl_busy_after", bus.busy, 32'h0);
    chk("fl_ready_after", bus.in_ready, 1'b1);
    chk("fl_issue_after", bus.issue_valid, 1'b1);
    step();
    idle();
    chk("fl_sgnjx_wbv", bus.wb_valid, 1'b1);
    chk("fl_sgnjx_wbrd", bus.wb_rd, 5'd2);
    chk("fl_sgnjx_wbop", bus.wb_op, FSGNJX);
    step();
    for (int i = 7; i <= 13; i++) begin
      idle();
      chk($sformatf("fl_no_wb_T%0d", i), bus.wb_valid, 1'b0);
      step();
    end

    // Unary FSQRT ignores busy rs2; binary op with the same rs2 stalls
    apply(1'b0, 1'b0, 1'b1, FDIV, 5'd9, 5'd1, 5'd3);
    chk("sq_div_issue", bus.issue_valid, 1'b1);
    step();
    apply(1'b0, 1'b0, 1'b0, FADD, 5'd5, 5'd0, 5'd9);
    chk("sq_binary_rs2_stall", bus.in_ready, 1'b0);
    apply(1'b0, 1'b0, 1'b1, FSQRT, 5'd1, 5'd0, 5'd9);
    chk("sq_busy9", bus.busy, 32'h200);
    chk("sq_ready", bus.in_ready, 1'b1);
    chk("sq_issue", bus.issue_valid, 1'b1);
    step();
    for (int i = 1; i <= 12; i++) begin
      idle();
      if (i == 11) begin
        chk("sq_div_wbrd", bus.wb_rd, 5'd9);
        chk("sq_div_wbop", bus.wb_op, FDIV);
      end
      if (i == 12) begin
        chk("sq_wbv", bus.wb_valid, 1'b1);
        chk("sq_wbrd", bus.wb_rd, 5'd1);
        chk("sq_wbop", bus.wb_op, FSQRT);
      end
      if (i < 11) chk("sq_no_early_wb", bus.wb_valid, 1'b0);
      step();
    end

    // Random traffic against due-time model
    apply(1'b1, 1'b0, 1'b0, FADD, 5'd0, 5'd0, 5'd0);
    step();
    pq.delete();
    e_ill = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r_r  = ($urandom_range(0, 199) == 0);
      r_f  = ($urandom_range(0, 63) == 0);
      r_v  = ($urandom_range(0, 3) != 0);
      r_k  = int'($urandom_range(0, 11));
      r_op = (r_k <= 9) ? 4'(r_k) : 4'(10 + $urandom_range(0, 5));
      r_rd = 5'($urandom_range(0, 7));
      r_rs1 = 5'($urandom_range(0, 7));
      r_rs2 = 5'($urandom_range(0, 7));
      apply(r_r, r_f, r_v, r_op, r_rd, r_rs1, r_rs2);

      e_busy = 32'h0; e_wbv = 1'b0; e_wbrd = 5'd0; e_wbop = 4'd0;
      r_lat = m_lat(r_op);
      e_free = 1'b1;
      foreach (pq[j]) begin
        if (pq[j].due >= c) e_busy[pq[j].rd] = 1'b1;
        if (pq[j].due == c) begin e_wbv = 1'b1; e_wbrd = pq[j].rd; e_wbop = pq[j].op; end
        if (pq[j].due == c + r_lat) e_free = 1'b0;
      end
      e_rdy = !r_r && !r_f && !e_busy[r_rs1] && (is_unary(r_op) || !e_busy[r_rs2])
              && !e_busy[r_rd] && e_free;
      e_acc = r_v && e_rdy;
      e_iss = e_acc && (r_op <= 4'd9);

      chk("rnd_ready",   bus.in_ready,    e_rdy);
      chk("rnd_issue",   bus.issue_valid, e_iss);
      chk("rnd_issueop", bus.issue_op,    r_op);
      chk("rnd_wbv",     bus.wb_valid,    e_wbv);
      chk("rnd_wbrd",    bus.wb_rd,       e_wbrd);
      chk("rnd_wbop",    bus.wb_op,       e_wbop);
      chk("rnd_busy",    bus.busy,        e_busy);
      chk("rnd_illegal", bus.illegal_op,  e_ill);

      keep.delete();
      foreach (pq[j]) if (pq[j].due > c) keep.push_back(pq[j]);
      pq = keep;
      if (r_r || r_f) pq.delete();
      else if (e_iss) pq.push_back('{due: c + r_lat, rd: r_rd, op: r_op});
      e_ill_nxt = e_acc && (r_op > 4'd9);
      e_ill = e_ill_nxt;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
